// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-byte holding register
// with valid/read handshake, sticky overrun and one-cycle framing-error pulse.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       rd_i,
    output logic [7:0] rxbyte_o,
    output logic       rx_valid_o,
    output logic       overrun_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    if (CLKS_PER_BIT < 4) begin : gen_param_check
        $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
    end

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] Half = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q;
    logic            sync_q;
    logic            rx_s_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            done_q;
    logic            done_ok_q;
    logic [7:0]      rxbyte_q;
    logic            rx_valid_q;
    logic            overrun_q;
    logic            frame_err_q;
    logic            busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sync_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            done_ok_q   <= 1'b0;
            rxbyte_q    <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= rx_i;
            rx_s_q      <= sync_q;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;

            if (rd_i && rx_valid_q) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            // Stop-bit result is committed one cycle after the sample; a load overrides a same-cycle rd.
            if (done_q) begin
                if (done_ok_q) begin
                    if (!rx_valid_q || rd_i) begin
                        rxbyte_q   <= shift_q;
                        rx_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    frame_err_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt_q == Half) begin
                        if (!rx_s_q) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == Last) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == Last) begin
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        done_ok_q <= rx_s_q;
                        if (rx_s_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    // A held-low line must go high before another start bit can be seen.
                    if (rx_s_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rxbyte_o    = rxbyte_q;
    assign rx_valid_o  = rx_valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1 at CLKS_PER_BIT=16: scoreboard of expected bytes and arrival cycles,
// checked when rx_valid rises, plus directed error and reset scenarios.
module tb_uart_rx_8n1;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2 - 1;
    localparam int unsigned LAT  = 3 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] rxbyte;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_i       (rx),
        .rd_i       (rd),
        .rxbyte_o   (rxbyte),
        .rx_valid_o (rx_valid),
        .overrun_o  (overrun),
        .frame_err_o(frame_err),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc    = 0;
    int unsigned fe_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int unsigned lat_q[$];
    int unsigned last_start;

    // Called at a negedge; cycle after the next posedge is the first edge sampling rx low.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int unsigned stop_len,
                              input bit push);
        rx = 1'b0;
        last_start = cyc;
        if (push) begin
            exp_q.push_back(d);
            lat_q.push_back(cyc + 1 + LAT);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_valid(output bit ok, output int unsigned at);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        rd  = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rxbyte !== 8'h00) begin
            miscompares++; $display("FAIL reset_rxbyte: got %h, expected 00", rxbyte);
        end
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++; $display("FAIL reset_overrun: got %b, expected 0", overrun);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        bit          ok;
        int unsigned at;
        logic [7:0]  eb;
        int unsigned el;
        int unsigned fe0 = fe_cnt;
        fork
            send_frame(8'hA5, 1'b1, CPB, 1'b1);
            wait_valid(ok, at);
        join
        eb = exp_q.pop_front();
        el = lat_q.pop_front();
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL single_valid: rx_valid never rose, expected a byte");
        end else begin
            vectors++;
            if (rxbyte !== eb) begin
                miscompares++; $display("FAIL single_byte: got %h, expected %h", rxbyte, eb);
            end
            vectors++;
            if (at !== el) begin
                miscompares++; $display("FAIL single_latency: rose at cycle %0d, expected %0d", at, el);
            end
        end
        vectors++;
        if (overrun !== 1'b0 || fe_cnt !== fe0) begin
            miscompares++;
            $display("FAIL single_errors: overrun=%b frame_err pulses=%0d, expected 0 and 0",
                     overrun, fe_cnt - fe0);
        end
        pulse_rd();
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_rd_clear: rx_valid=%b, expected 0", rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned fe0 = fe_cnt;
        fork
            begin
                send_frame(8'h44, 1'b1, CPB, 1'b1);
                send_frame(8'h00, 1'b1, CPB, 1'b1);
                send_frame(8'hFF, 1'b1, CPB, 1'b1);
            end
            begin
                bit          ok;
                int unsigned at;
                logic [7:0]  eb;
                int unsigned el;
                for (int n = 0; n < 3; n++) begin
                    wait_valid(ok, at);
                    vectors++;
                    if (!ok || exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL b2b_valid: frame %0d not received, expected a byte", n);
                    end else begin
                        eb = exp_q.pop_front();
                        el = lat_q.pop_front();
                        vectors++;
                        if (rxbyte !== eb) begin
                            miscompares++;
                            $display("FAIL b2b_byte: frame %0d got %h, expected %h", n, rxbyte, eb);
                        end
                        vectors++;
                        if (at !== el) begin
                            miscompares++;
                            $display("FAIL b2b_latency: frame %0d rose at %0d, expected %0d", n, at, el);
                        end
                    end
                    pulse_rd();
                end
            end
        join
        vectors++;
        if (overrun !== 1'b0 || fe_cnt !== fe0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_errors: overrun=%b fe=%0d leftover=%0d, expected 0 0 0",
                     overrun, fe_cnt - fe0, exp_q.size());
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_glitch();
        bit          saw_busy = 1'b0;
        bit          idle_seen = 1'b0;
        int unsigned fe0 = fe_cnt;
        rx = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        rx = 1'b1;
        for (int k = 0; k < HALF + 4; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle_seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!saw_busy) begin
            miscompares++; $display("FAIL glitch_busy_rise: busy never 1, expected 1");
        end
        vectors++;
        if (!idle_seen) begin
            miscompares++; $display("FAIL glitch_busy_fall: busy=%b after %0d cycles, expected 0", busy, HALF + 4);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b0 || fe_cnt !== fe0) begin
            miscompares++;
            $display("FAIL glitch_no_effect: rx_valid=%b fe=%0d, expected 0 0", rx_valid, fe_cnt - fe0);
        end
    endtask

    task automatic test_frame_err();
        bit          ok;
        int unsigned at;
        logic [7:0]  eb;
        int unsigned el;
        int unsigned fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 40, 1'b0);
        vectors++;
        if (fe_cnt !== fe0 + 1) begin
            miscompares++; $display("FAIL ferr_pulse: %0d high cycles, expected 1", fe_cnt - fe0);
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b0 || busy !== 1'b0 || fe_cnt !== fe0 + 1) begin
            miscompares++;
            $display("FAIL ferr_after: rx_valid=%b busy=%b fe=%0d, expected 0 0 1",
                     rx_valid, busy, fe_cnt - fe0);
        end
        fork
            send_frame(8'h96, 1'b1, CPB, 1'b1);
            wait_valid(ok, at);
        join
        eb = exp_q.pop_front();
        el = lat_q.pop_front();
        vectors++;
        if (!ok || rxbyte !== eb || at !== el) begin
            miscompares++;
            $display("FAIL ferr_recover: ok=%b byte=%h at=%0d, expected 1 %h %0d", ok, rxbyte, at, eb, el);
        end
        pulse_rd();
    endtask

    task automatic test_overrun();
        bit          ok;
        int unsigned at;
        logic [7:0]  eb;
        int unsigned el;
        fork
            send_frame(8'h11, 1'b1, CPB, 1'b1);
            wait_valid(ok, at);
        join
        eb = exp_q.pop_front();
        el = lat_q.pop_front();
        vectors++;
        if (!ok || rxbyte !== eb || at !== el) begin
            miscompares++;
            $display("FAIL ovr_first: ok=%b byte=%h at=%0d, expected 1 %h %0d", ok, rxbyte, at, eb, el);
        end
        send_frame(8'h22, 1'b1, CPB, 1'b0);
        vectors++;
        if (overrun !== 1'b1 || rxbyte !== 8'h11 || rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set: overrun=%b byte=%h valid=%b, expected 1 11 1", overrun, rxbyte, rx_valid);
        end
        pulse_rd();
        vectors++;
        if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear: overrun=%b valid=%b, expected 0 0", overrun, rx_valid);
        end
        fork
            send_frame(8'h11, 1'b1, CPB, 1'b1);
            wait_valid(ok, at);
        join
        eb = exp_q.pop_front();
        el = lat_q.pop_front();
        vectors++;
        if (!ok || rxbyte !== eb || at !== el) begin
            miscompares++;
            $display("FAIL ovr_again: ok=%b byte=%h at=%0d, expected 1 %h %0d", ok, rxbyte, at, eb, el);
        end
        fork
            send_frame(8'h22, 1'b1, CPB, 1'b0);
            begin
                #1;
                for (int k = 0; k < 400 && cyc != last_start + LAT; k++) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        vectors++;
        if (rxbyte !== 8'h22 || rx_valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_rd_load: byte=%h valid=%b overrun=%b, expected 22 1 0",
                     rxbyte, rx_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        int unsigned at;
        logic [7:0]  eb;
        int unsigned el;
        fork
            send_frame(8'hC3, 1'b1, CPB, 1'b0);
            begin
                #1;
                for (int k = 0; k < 400 && cyc != last_start + 88; k++) @(negedge clk);
                rst = 1'b1;
                #1;
                vectors++;
                if (rxbyte !== 8'h00 || rx_valid !== 1'b0 || overrun !== 1'b0 ||
                    frame_err !== 1'b0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrst_outputs: byte=%h valid=%b ovr=%b fe=%b busy=%b, expected 00 0 0 0 0",
                             rxbyte, rx_valid, overrun, frame_err, busy);
                end
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: valid=%b busy=%b, expected 0 0", rx_valid, busy);
        end
        fork
            send_frame(8'h5A, 1'b1, CPB, 1'b1);
            wait_valid(ok, at);
        join
        eb = exp_q.pop_front();
        el = lat_q.pop_front();
        vectors++;
        if (!ok || rxbyte !== eb || at !== el) begin
            miscompares++;
            $display("FAIL midrst_next: ok=%b byte=%h at=%0d, expected 1 %h %0d", ok, rxbyte, at, eb, el);
        end
        pulse_rd();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
